// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow square wave in clk_in cycles
// and flags whether the period lies within tolerance of an expected value.
module clock_period_meter #(
    parameter int CNT_W      = 20,
    parameter int EXP_PERIOD = 120000,
    parameter int TOL        = 120,
    parameter int TIMEOUT    = 250000
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ack,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             in_range,
    output logic             timeout
);

    typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

    localparam logic [CNT_W:0]   EXP_W = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]   TOL_W = (CNT_W+1)'(TOL);
    localparam logic [CNT_W-1:0] TO_W  = CNT_W'(TIMEOUT);

    state_t           state;
    logic             s1, s2, s3;
    logic             rise, fall;
    logic             got_fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_cap;
    logic [CNT_W:0]   cnt_w;
    logic [CNT_W:0]   diff;
    logic             near;
    logic             hit_to;

    assign rise   = s2 & ~s3;
    assign fall   = ~s2 & s3;
    assign cnt_w  = {1'b0, cnt};
    assign diff   = (cnt_w >= EXP_W) ? cnt_w - EXP_W : EXP_W - cnt_w;
    assign near   = (diff <= TOL_W);
    assign hit_to = (cnt >= TO_W);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            cnt          <= '0;
            hi_cap       <= '0;
            got_fall     <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            period       <= '0;
            high_time    <= '0;
            in_range     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;

            if (rise)
                cnt <= CNT_W'(1);
            else if (cnt != '1)
                cnt <= cnt + 1'b1;

            unique case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ARM;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        timeout  <= 1'b0;
                        in_range <= 1'b0;
                    end
                end
                ARM: begin
                    if (rise) begin
                        state    <= MEAS;
                        hi_cap   <= '0;
                        got_fall <= 1'b0;
                    end else if (hit_to) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        timeout      <= 1'b1;
                        in_range     <= 1'b0;
                        period       <= '0;
                        high_time    <= '0;
                    end
                end
                MEAS: begin
                    if (fall && !got_fall) begin
                        hi_cap   <= cnt;
                        got_fall <= 1'b1;
                    end
                    // A rise with no fall seen is a sub-sync glitch: hi_cap stays 0
                    if (rise) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        period       <= cnt;
                        high_time    <= hi_cap;
                        in_range     <= near;
                    end else if (hit_to) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        result_valid <= 1'b1;
                        timeout      <= 1'b1;
                        in_range     <= 1'b0;
                        period       <= '0;
                        high_time    <= (fall && !got_fall) ? cnt : hi_cap;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        if (start) begin
                            state    <= ARM;
                            busy     <= 1'b1;
                            cnt      <= '0;
                            timeout  <= 1'b0;
                            in_range <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
